// File: rtl/alu_seq_exec.sv
// Sequential execute unit: single-cycle logic/arith/compare, iterative one-bit-per-cycle shifts.
// Define ALU_FAST_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
module alu_seq_exec #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam logic [3:0] OpAdd = 4'b0000;
  localparam logic [3:0] OpSub = 4'b0001;
  localparam logic [3:0] OpAnd = 4'b0010;
  localparam logic [3:0] OpOr  = 4'b0011;
  localparam logic [3:0] OpXor = 4'b0100;
  localparam logic [3:0] OpSlt = 4'b0101;
  localparam logic [3:0] OpSll = 4'b0110;
  localparam logic [3:0] OpSrl = 4'b0111;
  localparam logic [3:0] OpSra = 4'b1000;

`ifdef ALU_FAST_SHIFT_EN
  typedef enum logic [1:0] {StIdle, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;
  typedef enum logic [1:0] {ShSll, ShSrl, ShSra} sh_op_e;
`endif

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               illegal_q, illegal_d;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   op_result;
  logic               op_illegal;

`ifndef ALU_FAST_SHIFT_EN
  logic [WIDTH-1:0]   acc_q, acc_d, acc_step;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  sh_op_e             sh_op_q, sh_op_d, op_sh_kind;
  logic               op_shift;
`endif

  assign shamt = src_b[SHAMT_W-1:0];

  // Operation decode; in the iterative build a shift just forwards src_a (the k = 0 result).
  always_comb begin
    op_result  = '0;
    op_illegal = 1'b0;
`ifndef ALU_FAST_SHIFT_EN
    op_shift   = 1'b0;
    op_sh_kind = ShSll;
`endif
    case (alu_control)
      OpAdd: op_result = src_a + src_b;
      OpSub: op_result = src_a - src_b;
      OpAnd: op_result = src_a & src_b;
      OpOr:  op_result = src_a | src_b;
      OpXor: op_result = src_a ^ src_b;
      OpSlt: op_result = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
`ifdef ALU_FAST_SHIFT_EN
      OpSll: op_result = src_a << shamt;
      OpSrl: op_result = src_a >> shamt;
      OpSra: op_result = $signed(src_a) >>> shamt;
`else
      OpSll: begin
        op_result  = src_a;
        op_shift   = 1'b1;
        op_sh_kind = ShSll;
      end
      OpSrl: begin
        op_result  = src_a;
        op_shift   = 1'b1;
        op_sh_kind = ShSrl;
      end
      OpSra: begin
        op_result  = src_a;
        op_shift   = 1'b1;
        op_sh_kind = ShSra;
      end
`endif
      default: op_illegal = 1'b1;
    endcase
  end

`ifndef ALU_FAST_SHIFT_EN
  always_comb begin
    case (sh_op_q)
      ShSll:   acc_step = acc_q << 1;
      ShSrl:   acc_step = acc_q >> 1;
      default: acc_step = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
    endcase
  end
`endif

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
`ifndef ALU_FAST_SHIFT_EN
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sh_op_d   = sh_op_q;
`endif
    if (flush) begin
      // Abort keeps the last visible result; only control state is cleared.
      state_d = StIdle;
`ifndef ALU_FAST_SHIFT_EN
      cnt_d   = '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
`ifndef ALU_FAST_SHIFT_EN
            if (op_shift && (shamt != '0)) begin
              acc_d   = src_a;
              cnt_d   = shamt;
              sh_op_d = op_sh_kind;
              state_d = StShift;
            end else
`endif
            begin
              result_d  = op_result;
              zero_d    = (op_result == '0);
              illegal_d = op_illegal;
              state_d   = StDone;
            end
          end
        end
`ifndef ALU_FAST_SHIFT_EN
        StShift: begin
          acc_d = acc_step;
          cnt_d = cnt_q - SHAMT_W'(1);
          if (cnt_q == SHAMT_W'(1)) begin
            result_d  = acc_step;
            zero_d    = (acc_step == '0);
            illegal_d = 1'b0;
            state_d   = StDone;
          end
        end
`endif
        StDone: begin
          if (out_ready) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
      acc_q     <= '0;
      cnt_q     <= '0;
      sh_op_q   <= ShSll;
`endif
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
`ifndef ALU_FAST_SHIFT_EN
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sh_op_q   <= sh_op_d;
`endif
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Scoreboard bench for alu_seq_exec: directed ops push expectations, a monitor pops on handshake.
module tb_alu_seq_exec;

`ifdef ALU_FAST_SHIFT_EN
  localparam bit Fast = 1'b1;
`else
  localparam bit Fast = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_control = 4'b0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  alu_seq_exec #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        il;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   first_cyc = 0;
  logic prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
  endtask

  function automatic int slat(input int k);
    return Fast ? 0 : k;
  endfunction

  // Monitor: pops one expectation per output handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !prev_valid) first_cyc = cyc;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("result", result, e.res);
          check("zero", {31'd0, zero}, {31'd0, e.z});
          check("illegal", {31'd0, illegal}, {31'd0, e.il});
          check("latency", 32'(first_cyc - e.acc), 32'(e.lat));
        end
      end
    end
    prev_valid = out_valid;
  end

  // Called at posedge+#1; the op is accepted at the following edge.
  task automatic issue(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [31:0] er, input bit ez, input bit ei,
                       input int lat);
    int guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
    in_valid    = 1'b1;
    alu_control = ctl;
    src_a       = a;
    src_b       = b;
    if (push) exp_q.push_back('{res: er, z: ez, il: ei, lat: lat, acc: cyc + 1});
    @(posedge clk); #1;
    in_valid    = 1'b0;
    alu_control = 4'b0011;
    src_a       = 32'hDEAD_BEEF;
    src_b       = 32'h1234_5678;
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int guard;
    #3;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(4'b0000, 32'h0000_0005, 32'hFFFF_FFFB, 1, 32'h0, 1, 0, 0);
    issue(4'b0101, 32'hFFFF_FFFF, 32'h0000_0001, 1, 32'h1, 0, 0, 0);
    issue(4'b0001, 32'hFFFF_FFFF, 32'h0000_0001, 1, 32'hFFFF_FFFE, 0, 0, 0);
    issue(4'b0101, 32'h0000_0001, 32'hFFFF_FFFF, 1, 32'h0, 1, 0, 0);
    issue(4'b0010, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, 32'hF000_F000, 0, 0, 0);
    issue(4'b0100, 32'h0000_1234, 32'h0000_1234, 1, 32'h0, 1, 0, 0);
    issue(4'b1000, 32'h8000_0000, 32'd31, 1, 32'hFFFF_FFFF, 0, 0, slat(31));
    issue(4'b0111, 32'h8000_0000, 32'd31, 1, 32'h0000_0001, 0, 0, slat(31));
    issue(4'b0110, 32'h1234_5678, 32'h0000_0020, 1, 32'h1234_5678, 0, 0, 0);
    issue(4'b0110, 32'h0000_0001, 32'd1, 1, 32'h0000_0002, 0, 0, slat(1));
    drain();

    // Backpressure: result held, no new accept while the consumer stalls.
    out_ready = 1'b0;
    issue(4'b0111, 32'hF000_0000, 32'd4, 1, 32'h0F00_0000, 0, 0, slat(4));
    guard = 0;
    while (!out_valid && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    for (int i = 0; i < 10; i++) begin
      check("bp_result", result, 32'h0F00_0000);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_in_ready", {31'd0, in_ready}, 32'd1);
    check("bp_idle_out_valid", {31'd0, out_valid}, 32'd0);

    // Flush mid-shift: the op must vanish without ever raising out_valid.
    issue(4'b0110, 32'h0000_0001, 32'd20, 0, 32'h0, 0, 0, 0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    repeat (25) begin
      @(posedge clk); #1;
    end
    issue(4'b0011, 32'h0000_00F0, 32'h0000_0F00, 1, 32'h0000_0FF0, 0, 0, 0);
    drain();

    // Flush in IDLE blocks the accept.
    flush = 1'b1;
    in_valid = 1'b1;
    alu_control = 4'b0000;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_idle_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_idle_in_ready", {31'd0, in_ready}, 32'd1);

    issue(4'b1010, 32'h1111_1111, 32'h2222_2222, 1, 32'h0, 1, 1, 0);
    drain();

    // Asynchronous reset in the middle of a shift.
    issue(4'b0110, 32'h0000_0001, 32'd20, 0, 32'h0, 0, 0, 0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    check("arst_result", result, 32'd0);
    check("arst_zero", {31'd0, zero}, 32'd0);
    check("arst_illegal", {31'd0, illegal}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(4'b0000, 32'd7, 32'd8, 1, 32'd15, 0, 0, 0);
    drain();
    repeat (30) begin
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
